ex_muldiv: RTL and testbench
============================

# ex_muldiv

Parametrised iterative multiply/divide unit for the execute stage, owning the architectural HI/LO register pair. It runs alongside the single-cycle ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the ID/EX boundary. While an operation is in flight it raises a stall request, and it pulses completion when HI/LO are written. Supported operand widths are 4..64 bits. It supports pipeline flush and flags divide-by-zero.

## Interface
- WIDTH, 32, operand and HI/LO width; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  valid operation presented this cycle.
- op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op.
- src_a  in  WIDTH  forwarded rs operand (multiplicand/dividend; MTHI/MTLO source).
- src_b  in  WIDTH  forwarded rt operand (multiplier/divisor).
- flush  in  1  abort the in-flight operation.
- busy  out  1  stall request to the hazard unit; registered.
- done  out  1  one-cycle pulse when a mul/div completes.
- div_by_zero  out  1  valid only with done; 1 = divisor was zero.
- hi  out  WIDTH  HI register (MFHI reads this directly).
- lo  out  WIDTH  LO register (MFLO reads this directly).

## Operation
- Reset (async, rst_n=0):
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - State IDLE; iteration counter 0.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, flush=0:
  - MTHI writes hi<=src_a; MTLO writes lo<=src_a. Single cycle; no busy, no done.
  - MULT/MULTU: latch operand magnitudes and sign flags, go to MUL.
  - DIV/DIVU with src_b≠0: latch operand magnitudes and sign flags, go to DIV.
  - DIV/DIVU with src_b=0: go straight to FIX with a divide-by-zero flag.
  - op 110/111: ignored.
- Operand capture:
  - Unsigned ops use the operands as-is.
  - Signed ops capture |x| and record the sign of each operand.
- MUL: shift-add radix-2, one multiplier bit per cycle, 2·WIDTH-bit accumulator, exactly WIDTH cycles, then FIX.
- DIV: restoring shift-subtract, one quotient bit per cycle, WIDTH-bit remainder with carry bit, exactly WIDTH cycles, then FIX.
- FIX (one cycle), sign correction:
  - Signed product: negated if operand signs differ; hi=upper WIDTH bits, lo=lower WIDTH bits.
  - Quotient: negated if signs differ.
  - Remainder: takes the dividend's sign; lo=quotient, hi=remainder.
  - Negation is modulo 2^WIDTH, so most-negative ÷ −1 yields lo=most-negative, hi=0.
  - Divide by zero: hi/lo unchanged, div_by_zero=1.
  - done=1 in FIX; next state IDLE.
- busy = (state ≠ IDLE).
  - start while busy is ignored; the pipeline must already be held.
  - MTHI/MTLO are never accepted while busy.
- flush=1: next edge returns to IDLE.
  - No hi/lo write and no done, even if the current state is FIX.
  - start in the same cycle as flush is ignored.

## Timing
- Start accepted at edge k (start=1 sampled in IDLE).
- Normal mul/div:
  - busy=1 for cycles k+1 .. k+WIDTH+1 (WIDTH+1 cycles).
  - FIX occupies cycle k+WIDTH+1: done=1, and hi/lo update at the edge ending that cycle.
  - busy=0 and new hi/lo visible from cycle k+WIDTH+2.
- Divide by zero: busy=1, done=1, div_by_zero=1 in cycle k+1 only.
- MTHI/MTLO: new value visible in cycle k+1.
- A new op may be accepted in the first cycle busy=0.
- flush raised in cycle j while busy: busy=0 from cycle j+1.
- rst_n asserted mid-operation: all outputs clear immediately, with no clock edge required.
- No combinational path from start/op/src_* to busy or done.

## Test plan
- MULT, WIDTH=32, src_a=0xFFFFFFFD, src_b=7:
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - busy high exactly 33 cycles; single done pulse in the last busy cycle.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULT 0x80000000×0x80000000 -> hi=0x40000000, lo=0.
- Divides:
  - DIV −7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/2 -> lo=3, hi=1.
  - DIV 7/−2 -> lo=0xFFFFFFFD, hi=1.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0x5678 (no busy), then DIV 5/0:
  - busy, done and div_by_zero high for one cycle.
  - hi=0x1234, lo=0x5678 unchanged.
- MULTU 3×5 started with flush in the 10th busy cycle:
  - busy low next cycle, no done, hi/lo unchanged.
  - A start asserted during busy is never accepted.
- DIVU in flight, rst_n pulsed low mid-operation -> hi=lo=0, busy=0 immediately. Repeat with WIDTH=8: MULT 0xFD×0x07 -> hi=0xFF, lo=0xEB, busy 9 cycles.

Source files
------------

// File: rtl/ex_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ex_muldiv : iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.    |
// | Rev 1.0   : initial release                                              |
// +--------------------------------------------------------------------------+
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                 c_cnt_w   = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
  localparam logic [2:0]         c_op_mthi = 3'b100;
  localparam logic [2:0]         c_op_mtlo = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t               r_state, w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opb;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_is_div, r_neg_res, r_neg_rem, r_dbz;

  logic                 w_accept, w_is_mul, w_is_div, w_signed;
  logic                 w_a_neg, w_b_neg;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b;
  logic [WIDTH:0]       w_mul_sum, w_trial;
  logic [2*WIDTH-1:0]   w_mul_nxt, w_div_nxt, w_prod;
  logic [WIDTH-1:0]     w_quo, w_rem;

  assign w_accept = (r_state == S_IDLE) && start && !flush;
  assign w_is_mul = (op[2:1] == 2'b00);
  assign w_is_div = (op[2:1] == 2'b01);
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & src_a[WIDTH-1];
  assign w_b_neg  = w_signed & src_b[WIDTH-1];
  assign w_mag_a  = w_a_neg ? -src_a : src_a;
  assign w_mag_b  = w_b_neg ? -src_b : src_b;

  // Shift-add: upper half accumulates with a carry bit, multiplier drains from the low end.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opb : '0)};
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: acc holds {remainder, dividend/quotient}; bit WIDTH of trial is the borrow.
  assign w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opb};
  assign w_div_nxt = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                    : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_is_mul)      w_state_nxt = S_MUL;
        else if (w_accept && w_is_div) w_state_nxt = (src_b == '0) ? S_FIX : S_DIV;
      end
      S_MUL:   if (r_cnt == c_last) w_state_nxt = S_FIX;
      S_DIV:   if (r_cnt == c_last) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= '0;
            r_is_div  <= w_is_div;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_dbz     <= w_is_div && (src_b == '0);
            if (op == c_op_mthi) r_hi <= src_a;
            if (op == c_op_mtlo) r_lo <= src_a;
            if (w_is_mul) begin
              r_acc <= {{WIDTH{1'b0}}, w_mag_b};
              r_opb <= w_mag_a;
            end else if (w_is_div) begin
              r_acc <= {{WIDTH{1'b0}}, w_mag_a};
              r_opb <= w_mag_b;
            end
          end
        end
        S_MUL: begin
          r_acc <= w_mul_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_DIV: begin
          r_acc <= w_div_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (!flush && !r_dbz) begin
            if (r_is_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // done is gated by flush so an aborted FIX never reports completion.
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_FIX) && !flush;
  assign div_by_zero = done && r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ex_muldiv : self-checking bench for ex_muldiv (WIDTH=32 and WIDTH=8). |
// | Rev 1.0      : initial release                                           |
// +--------------------------------------------------------------------------+
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, flush = 1'b0;
  logic [2:0]  op = 3'b110;
  logic [31:0] src_a = '0, src_b = '0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0, flush8 = 1'b0;
  logic [2:0]  op8 = 3'b110;
  logic [7:0]  src_a8 = '0, src_b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(dz), .hi(hi), .lo(lo)
  );

  ex_muldiv #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .src_a(src_a8), .src_b(src_b8),
    .flush(flush8), .busy(busy8), .done(done8), .div_by_zero(dz8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Architectural result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] f_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sq, sr;
    logic [63:0] r;
    r = '0;
    case (o)
      3'b000: r = longint'($signed(a)) * longint'($signed(b));
      3'b001: r = {32'b0, a} * {32'b0, b};
      3'b010: begin
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        r  = {sr[31:0], sq[31:0]};
      end
      3'b011: r = {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Timeline model: m_left counts remaining busy cycles (last one is the completion cycle).
  int          m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_res = '0;
  logic        m_dbz = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_dbz  <= 1'b0;
    end else if (m_left > 0) begin
      if (flush) m_left <= 0;
      else begin
        if (m_left == 1 && !m_dbz) begin
          m_hi <= m_res[63:32];
          m_lo <= m_res[31:0];
        end
        m_left <= m_left - 1;
      end
    end else if (start && !flush) begin
      if (op == 3'b100) m_hi <= src_a;
      else if (op == 3'b101) m_lo <= src_a;
      else if (op[2] == 1'b0) begin
        m_dbz  <= op[1] && (src_b == 0);
        m_left <= (op[1] && src_b == 0) ? 1 : 33;
        m_res  <= (op[1] && src_b == 0) ? 64'd0 : f_result(op, src_a, src_b);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_left > 0);
      chk("done", done, (m_left == 1) && !flush);
      chk("div_by_zero", dz, (m_left == 1) && !flush && m_dbz);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_dz);
    int nb, nd, nz, done_at;
    nb = 0; nd = 0; nz = 0; done_at = -1;
    @(posedge clk); #1 start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1 start = 1'b0; op = 3'b110;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
      if (done) begin nd++; done_at = nb; end
      if (done && dz) nz++;
    end
    chk({nm, " busy cycles"}, nb, exp_busy);
    chk({nm, " done pulses"}, nd, 1);
    chk({nm, " done in last busy cycle"}, done_at, nb);
    chk({nm, " dbz pulses"}, nz, exp_dz);
    chk({nm, " hi"}, hi, exp_hi);
    chk({nm, " lo"}, lo, exp_lo);
  endtask

  task automatic move_to(input logic [2:0] o, input logic [31:0] a, input string nm,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(posedge clk); #1 start = 1'b1; op = o; src_a = a;
    @(posedge clk); #1 start = 1'b0; op = 3'b110;
    @(negedge clk);
    chk({nm, " busy"}, busy, 1'b0);
    chk({nm, " hi"}, hi, exp_hi);
    chk({nm, " lo"}, lo, exp_lo);
  endtask

  initial begin
    int nb8;
    #23;
    chk("reset busy", busy, 1'b0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    chk("reset done", done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    chk_en = 1'b1;

    run_op("MULT -3*7", 3'b000, 32'hFFFFFFFD, 32'h7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run_op("MULTU max*max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("MULT min*min", 3'b000, 32'h80000000, 32'h80000000, 33, 32'h40000000, 32'h0, 0);
    run_op("DIV -7/2", 3'b010, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("DIVU 7/2", 3'b011, 32'h7, 32'h2, 33, 32'h1, 32'h3, 0);
    run_op("DIV 7/-2", 3'b010, 32'h7, 32'hFFFFFFFE, 33, 32'h1, 32'hFFFFFFFD, 0);
    run_op("DIV min/-1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000, 0);

    move_to(3'b100, 32'h1234, "MTHI", 32'h1234, 32'h80000000);
    move_to(3'b101, 32'h5678, "MTLO", 32'h1234, 32'h5678);
    run_op("DIV 5/0", 3'b010, 32'h5, 32'h0, 1, 32'h1234, 32'h5678, 1);

    // MULTU 3*5, then keep start high with other operands and flush in the 10th busy cycle.
    @(posedge clk); #1 start = 1'b1; op = 3'b001; src_a = 32'h3; src_b = 32'h5;
    @(posedge clk); #1 src_a = 32'h9; src_b = 32'h9;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush cycle busy", busy, 1'b1);
    @(posedge clk); #1 flush = 1'b0; start = 1'b0; op = 3'b110;
    @(negedge clk);
    chk("after flush busy", busy, 1'b0);
    chk("after flush done", done, 1'b0);
    repeat (3) @(negedge clk);
    chk("after flush hi", hi, 32'h1234);
    chk("after flush lo", lo, 32'h5678);
    chk("after flush idle", busy, 1'b0);

    // Asynchronous reset in the middle of a DIVU.
    @(posedge clk); #1 start = 1'b1; op = 3'b011; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1 start = 1'b0; op = 3'b110;
    repeat (5) @(posedge clk);
    #2;
    chk("pre-reset busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async reset busy", busy, 1'b0);
    chk("async reset hi", hi, 32'h0);
    chk("async reset lo", lo, 32'h0);
    @(negedge clk); #1 rst_n = 1'b1;

    // WIDTH=8: MULT 0xFD*0x07 = -21.
    @(posedge clk); #1 start8 = 1'b1; op8 = 3'b000; src_a8 = 8'hFD; src_b8 = 8'h07;
    @(posedge clk); #1 start8 = 1'b0; op8 = 3'b110;
    nb8 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy8) break;
      nb8++;
    end
    chk("W8 MULT busy cycles", nb8, 9);
    chk("W8 MULT hi", hi8, 8'hFF);
    chk("W8 MULT lo", lo8, 8'hEB);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
